// File: rtl/mips_alu_pkg.sv
// +---------------------------------------------------------------------------+
// | Module   : mips_alu_pkg                                                   |
// | Purpose  : Shared ALU opcodes/selects, HI/LO op codes and the sequencer   |
// |            state encoding used by mul_div_sequencer and mul_div_step.     |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

package mips_alu_pkg;

    localparam logic [2:0] ALU_OP_ADD   = 3'b010;
    localparam logic [2:0] ALU_OP_SUB   = 3'b110;
    localparam logic [2:0] ALU_SEL_CORE = 3'b000;

    localparam logic MD_OP_MULTU = 1'b0;
    localparam logic MD_OP_DIVU  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

endpackage

`default_nettype wire

// File: rtl/mul_div_step.sv
// +---------------------------------------------------------------------------+
// | Module   : mul_div_step                                                   |
// | Purpose  : One bit of shift-add MULTU or restoring DIVU. Drives the       |
// |            shared ALU operands and forms next HI/LO from its result.      |
// |            DIVU datapath present only when MULDIV_DIVU_EN is defined.     |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module mul_div_step
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
`ifdef MULDIV_DIVU_EN
    input  logic             mode_i,
`endif
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic [WIDTH-1:0] alu_res_i,
    input  logic             alu_cout_i,
    output logic [WIDTH-1:0] hi_d_o,
    output logic [WIDTH-1:0] lo_d_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [2:0]       alu_op_o
);

`ifdef MULDIV_DIVU_EN
    // Partial remainder shifted left by one, pulling in the next dividend bit.
    logic [WIDTH-1:0] shifted;
    assign shifted = {hi_i[WIDTH-2:0], lo_i[WIDTH-1]};
`endif

    // Select ALU operands for the active mode and fold the ALU result into HI/LO.
    always_comb begin
        // MULTU: add multiplicand into HI when the current multiplier bit is set,
        // then shift the 65-bit {cout, sum, lo} right by one.
        alu_a_o  = hi_i;
        alu_b_o  = lo_i[0] ? opnd_i : '0;
        alu_op_o = ALU_OP_ADD;
        hi_d_o   = {alu_cout_i, alu_res_i[WIDTH-1:1]};
        lo_d_o   = {alu_res_i[0], lo_i[WIDTH-1:1]};
`ifdef MULDIV_DIVU_EN
        if (mode_i == MD_OP_DIVU) begin
            // Restoring step: a dropped HI MSB means the shifted value already
            // exceeds any 32-bit divisor, so the subtract is always taken.
            alu_a_o  = shifted;
            alu_b_o  = opnd_i;
            alu_op_o = ALU_OP_SUB;
            if (hi_i[WIDTH-1] | alu_cout_i) begin
                hi_d_o = alu_res_i;
                lo_d_o = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                hi_d_o = shifted;
                lo_d_o = {lo_i[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/mul_div_sequencer.sv
// +---------------------------------------------------------------------------+
// | Module   : mul_div_sequencer                                              |
// | Purpose  : Multi-cycle HI/LO unit. Runs MULTU (and DIVU when the macro    |
// |            MULDIV_DIVU_EN is defined) one bit per cycle on the shared     |
// |            32-bit ALU. Without the macro, DIVU reports err with done.     |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module mul_div_sequencer
    import mips_alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ITER_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_cout
);

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

    md_state_e          state_q;
    logic [ITER_W-1:0]  count_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
`ifdef MULDIV_DIVU_EN
    logic               mode_q;
`endif

    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;
    logic [WIDTH-1:0]   step_alu_a;
    logic [WIDTH-1:0]   step_alu_b;
    logic [2:0]         step_alu_op;

    mul_div_step #(
        .WIDTH      (WIDTH)
    ) u_step (
`ifdef MULDIV_DIVU_EN
        .mode_i     (mode_q),
`endif
        .hi_i       (hi_q),
        .lo_i       (lo_q),
        .opnd_i     (opnd_q),
        .alu_res_i  (alu_res),
        .alu_cout_i (alu_cout),
        .hi_d_o     (hi_d),
        .lo_d_o     (lo_d),
        .alu_a_o    (step_alu_a),
        .alu_b_o    (step_alu_b),
        .alu_op_o   (step_alu_op)
    );

    // Sequencer FSM: accept a start in IDLE, step WIDTH times, pulse done once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MULDIV_DIVU_EN
            mode_q  <= MD_OP_MULTU;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        if (md_op == MD_OP_MULTU) begin
                            opnd_q  <= rt_val;
                            hi_q    <= '0;
                            lo_q    <= rs_val;
                            state_q <= ST_RUN;
`ifdef MULDIV_DIVU_EN
                            mode_q  <= MD_OP_MULTU;
`endif
                        end else begin
`ifdef MULDIV_DIVU_EN
                            if (rt_val == '0) begin
                                // Divide-by-zero: fixed result, no iterations.
                                hi_q    <= rs_val;
                                lo_q    <= '1;
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                err_q   <= 1'b1;
                            end else begin
                                opnd_q  <= rt_val;
                                hi_q    <= '0;
                                lo_q    <= rs_val;
                                mode_q  <= MD_OP_DIVU;
                                state_q <= ST_RUN;
                            end
`else
                            // DIVU not built: report and leave HI/LO untouched.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
`endif
                        end
                    end
                end
                ST_RUN: begin
                    hi_q <= hi_d;
                    lo_q <= lo_d;
                    if (count_q == LAST_ITER) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // The ALU is only borrowed while iterating; otherwise present an idle ADD 0+0.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_OP_ADD;
        if (state_q == ST_RUN) begin
            alu_a  = step_alu_a;
            alu_b  = step_alu_b;
            alu_op = step_alu_op;
        end
    end

    assign alu_sel = ALU_SEL_CORE;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_sequencer.sv
// +---------------------------------------------------------------------------+
// | Module   : tb_mul_div_sequencer                                           |
// | Purpose  : Directed vector bench for mul_div_sequencer with a behavioural |
// |            model of the shared ALU. DIVU vectors follow MULDIV_DIVU_EN.   |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_mul_div_sequencer;
    import mips_alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        md_op = 1'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy, done, err;
    logic [31:0] hi, lo, alu_a, alu_b, alu_res;
    logic [2:0]  alu_op, alu_sel;
    logic        alu_cout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[$];

    mul_div_sequencer #(.WIDTH(32), .ITER_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .hi       (hi),
        .lo       (lo),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_sel  (alu_sel),
        .alu_res  (alu_res),
        .alu_cout (alu_cout)
    );

    always #5 clk = ~clk;

    // Shared ALU: ADD gives carry-out, SUB gives carry = no-borrow (A >= B).
    always_comb begin
        if (alu_op == ALU_OP_SUB)
            {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        else
            {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done; cyc=0 means timeout.
    task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output logic e);
        @(negedge clk);
        md_op  = op;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        e   = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done) begin
                cyc = c;
                e   = err;
                break;
            end
        end
    endtask

    initial begin
        int   cyc;
        logic e;
        int   ndone;
        int   dcyc;

        vecs.push_back('{MD_OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 33});
        vecs.push_back('{MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33});
        vecs.push_back('{MD_OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 33});
        vecs.push_back('{MD_OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33});
        vecs.push_back('{MD_OP_MULTU, 32'd0, 32'd12345, 32'd0, 32'd0, 1'b0, 33});
        vecs.push_back('{MD_OP_MULTU, 32'd1000000, 32'd1000000, 32'h000000E8, 32'hD4A51000, 1'b0, 33});
`ifdef MULDIV_DIVU_EN
        vecs.push_back('{MD_OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33});
        vecs.push_back('{MD_OP_DIVU, 32'h80000000, 32'd1, 32'd0, 32'h80000000, 1'b0, 33});
        vecs.push_back('{MD_OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1});
        vecs.push_back('{MD_OP_DIVU, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'd1, 1'b0, 33});
        vecs.push_back('{MD_OP_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0, 33});
`else
        // Unsupported DIVU keeps the previous product in HI/LO.
        vecs.push_back('{MD_OP_DIVU, 32'd100, 32'd7, 32'h000000E8, 32'hD4A51000, 1'b1, 1});
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err",  64'(err),  64'd0);
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_lo",   64'(lo),   64'd0);
        chk("rst_alu",  {26'd0, alu_op, alu_sel, alu_a[15:0], alu_b[15:0]}, {26'd0, ALU_OP_ADD, ALU_SEL_CORE, 32'd0});

        // Table-driven vectors
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, e);
            chk($sformatf("v%0d_cyc", i), 64'(cyc), 64'(vecs[i].exp_cyc));
            chk($sformatf("v%0d_err", i), 64'(e), 64'(vecs[i].exp_err));
            chk($sformatf("v%0d_hilo", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
            @(negedge clk);
            chk($sformatf("v%0d_idle", i), {62'd0, busy, done}, 64'd0);
        end

        // Starts during RUN are ignored; exactly one done at cycle 33
        @(negedge clk);
        md_op = MD_OP_MULTU; rs_val = 32'd7; rt_val = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        dcyc  = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 2) begin
                chk("run_busy", 64'(busy), 64'd1);
                chk("run_sel", 64'(alu_sel), 64'(ALU_SEL_CORE));
                chk("run_op", 64'(alu_op), 64'(ALU_OP_ADD));
            end
            if (done) begin
                ndone++;
                dcyc = c;
            end
            if (c == 5 || c == 20) begin
                rs_val = 32'd1; rt_val = 32'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk("busy_start_ndone", 64'(ndone), 64'd1);
        chk("busy_start_cyc", 64'(dcyc), 64'd33);
        chk("busy_start_hilo", {hi, lo}, {32'd0, 32'd63});
        repeat (3) @(negedge clk);
        chk("hold_hilo", {hi, lo}, {32'd0, 32'd63});

        // Reset in the middle of RUN abandons the operation
        @(negedge clk);
        md_op = MD_OP_MULTU; rs_val = 32'd123; rt_val = 32'd456; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        start = 1'b0;
        chk("midrst_state", {busy, done, err}, 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        do_op(MD_OP_MULTU, 32'd2, 32'd2, cyc, e);
        chk("after_rst_cyc", 64'(cyc), 64'd33);
        chk("after_rst_hilo", {hi, lo}, {32'd0, 32'd4});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
